// File: rtl/p18_vga_timing.sv
// Raster timing generator: signed h/v position, syncs, display enable,
// frame start strobe and the frame-divided animation time base.
module p18_vga_timing #(
  parameter int HACTIVE = 640,
  parameter int HFRONT = 16,
  parameter int HSYNC = 96,
  parameter int HBACK = 48,
  parameter int VACTIVE = 480,
  parameter int VFRONT = 10,
  parameter int VSYNC = 2,
  parameter int VBACK = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  localparam int HTOTAL = HACTIVE + HFRONT + HSYNC + HBACK,
  localparam int VTOTAL = VACTIVE + VFRONT + VSYNC + VBACK,
  localparam int HW = $clog2(HTOTAL) + 1,
  localparam int VW = $clog2(VTOTAL) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 anim_en,
  input  logic [1:0]           speed,
  output logic signed [HW-1:0] counter_h,
  output logic signed [VW-1:0] counter_v,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 display_on,
  output logic                 frame_start,
  output logic [7:0]           cur_time
);

  localparam int HBLANK = HFRONT + HSYNC + HBACK;
  localparam int VBLANK = VFRONT + VSYNC + VBACK;

  localparam logic signed [HW-1:0] H_MIN = HW'(-HBLANK);
  localparam logic signed [HW-1:0] H_MAX = HW'(HACTIVE - 1);
  localparam logic signed [HW-1:0] HS_LO = HW'(HFRONT - HBLANK);
  localparam logic signed [HW-1:0] HS_HI =
    HW'(HFRONT + HSYNC - 1 - HBLANK);

  localparam logic signed [VW-1:0] V_MIN = VW'(-VBLANK);
  localparam logic signed [VW-1:0] V_MAX = VW'(VACTIVE - 1);
  localparam logic signed [VW-1:0] VS_LO = VW'(VFRONT - VBLANK);
  localparam logic signed [VW-1:0] VS_HI =
    VW'(VFRONT + VSYNC - 1 - VBLANK);

  logic [2:0] div;
  logic [2:0] mask;
  logic [3:0] span;
  logic h_wrap;
  logic v_wrap;
  logic f_wrap;
  logic step;
  logic signed [HW-1:0] h_next;
  logic signed [VW-1:0] v_next;

  always_comb begin
    h_wrap = counter_h == H_MAX;
    v_wrap = counter_v == V_MAX;
    f_wrap = h_wrap && v_wrap;
    h_next = h_wrap ? H_MIN : counter_h + HW'(1);
    v_next = counter_v;
    if (h_wrap)
      v_next = v_wrap ? V_MIN : counter_v + VW'(1);
    span = 4'd1 << speed;
    mask = 3'(span - 4'd1);
    // speed=0 gives an empty mask, so every enabled wrap steps
    step = f_wrap && anim_en && ((div & mask) == mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter_h <= H_MIN;
      counter_v <= V_MIN;
      hsync <= !HSYNC_POL;
      vsync <= !VSYNC_POL;
      display_on <= 1'b0;
      frame_start <= 1'b1;
      cur_time <= 8'd0;
      div <= 3'd0;
    end else begin
      counter_h <= h_next;
      counter_v <= v_next;
      hsync <= (h_next >= HS_LO && h_next <= HS_HI) ?
               HSYNC_POL : !HSYNC_POL;
      vsync <= (v_next >= VS_LO && v_next <= VS_HI) ?
               VSYNC_POL : !VSYNC_POL;
      display_on <= !h_next[HW-1] && !v_next[VW-1];
      frame_start <= (h_next == H_MIN) && (v_next == V_MIN);
      if (f_wrap && anim_en)
        div <= div + 3'd1;
      if (step)
        cur_time <= cur_time + 8'd1;
    end
  end

endmodule
